// File: rtl/microwave_controller.sv
`default_nettype none
// ============================================================================
// Module   : microwave_controller
// Brief    : Sequencing FSM for the microwave. Drives the countdown timer's
//            load/enable/clear and gates the magnetron, lamp and beeper.
//            Optional macro QUICK_START_EN adds a one-touch 0:30 start.
// Revision : 1.0 - initial release
// ============================================================================
module microwave_controller #(
   parameter int BEEP_CYCLES = 3
) (
   input  logic       CLK,
   input  logic       Clearn,
   input  logic       start,
   input  logic       stop,
   input  logic       door_closed,
   input  logic       keypad_valid,
   input  logic       timer_done,
   output logic       load,
   output logic       enable,
   output logic       timer_clearn,
   output logic       mag_on,
   output logic       lamp_on,
   output logic       beep,
   output logic       quick_preset,
   output logic [2:0] state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SET   = 3'd1;
   localparam logic [2:0] S_COOK  = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_QLOAD = 3'd5;

   localparam logic [3:0] BEEP_MAX  = 4'(BEEP_CYCLES);
   localparam logic [3:0] BEEP_LAST = 4'(BEEP_CYCLES - 1);

   logic [2:0] state_q, state_d;
   logic       start_q, start_d;
   logic       stop_q, stop_d;
   logic [3:0] beep_cnt_q, beep_cnt_d;
   logic       clr_q, clr_d;

   logic       start_rise;
   logic       stop_rise;

   assign start_rise = start & ~start_q;
   assign stop_rise  = stop & ~stop_q;

   // State register
   always_ff @(posedge CLK or negedge Clearn) begin
      if (!Clearn) begin
         state_q    <= S_IDLE;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         beep_cnt_q <= 4'd0;
         clr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         beep_cnt_q <= beep_cnt_d;
         clr_q      <= clr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      start_d = start;
      stop_d  = stop;
      case (state_q)
         S_IDLE: begin
            if (keypad_valid) begin
               state_d = S_SET;
            end
`ifdef QUICK_START_EN
            else if (start_rise && door_closed) begin
               state_d = S_QLOAD;
            end
`endif
         end
         S_SET: begin
            if (stop_rise) begin
               state_d = S_IDLE;
            end else if (start_rise && door_closed && !timer_done) begin
               state_d = S_COOK;
            end
         end
         S_COOK: begin
            if (timer_done) begin
               state_d = S_DONE;
            end else if (!door_closed || stop_rise) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (stop_rise) begin
               state_d = S_IDLE;
            end else if (start_rise && door_closed) begin
               state_d = S_COOK;
            end
         end
         S_DONE: begin
            if (stop_rise || (beep_cnt_q == BEEP_LAST)) begin
               state_d = S_IDLE;
            end
         end
         S_QLOAD: begin
            state_d = S_COOK;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Counter is zero whenever DONE is entered, since it only runs inside DONE.
      beep_cnt_d = (state_q == S_DONE) ? beep_cnt_q + 4'd1 : 4'd0;

      clr_d = (state_d == S_IDLE) &&
              ((state_q == S_SET) || (state_q == S_PAUSE) || (state_q == S_DONE));
   end

   // Output decode
   always_comb begin
      load         = (state_q == S_SET) || (state_q == S_QLOAD);
      enable       = (state_q == S_COOK);
      mag_on       = (state_q == S_COOK);
      lamp_on      = (state_q == S_COOK) || (state_q == S_PAUSE);
      beep         = (state_q == S_DONE) && (beep_cnt_q < BEEP_MAX);
      timer_clearn = ~clr_q;
      state        = state_q;
`ifdef QUICK_START_EN
      quick_preset = (state_q == S_QLOAD);
`else
      quick_preset = 1'b0;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_microwave_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_microwave_controller
// Brief    : Directed bench for microwave_controller with a cycle-level
//            reference model and per-cycle output comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_microwave_controller;

   localparam int BEEP = 3;

   logic       CLK = 1'b0;
   logic       Clearn = 1'b0;
   logic       start = 1'b0, stop = 1'b0, door_closed = 1'b1;
   logic       keypad_valid = 1'b0, timer_done = 1'b0;
   logic       load, enable, timer_clearn, mag_on, lamp_on, beep, quick_preset;
   logic [2:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   microwave_controller #(.BEEP_CYCLES(BEEP)) dut (
      .CLK(CLK), .Clearn(Clearn), .start(start), .stop(stop),
      .door_closed(door_closed), .keypad_valid(keypad_valid),
      .timer_done(timer_done), .load(load), .enable(enable),
      .timer_clearn(timer_clearn), .mag_on(mag_on), .lamp_on(lamp_on),
      .beep(beep), .quick_preset(quick_preset), .state(state)
   );

   always #5 CLK = ~CLK;

`ifdef QUICK_START_EN
   localparam bit QUICK = 1'b1;
`else
   localparam bit QUICK = 1'b0;
`endif

   // Reference model: mode number, beeps still owed, and whether a clear is owed.
   int m_mode = 0;
   int m_beeps_left = 0;
   bit m_clear = 1'b0;
   bit m_ps = 1'b0, m_pp = 1'b0;

   always @(posedge CLK or negedge Clearn) begin
      if (!Clearn) begin
         m_mode = 0; m_beeps_left = 0; m_clear = 1'b0; m_ps = 1'b0; m_pp = 1'b0;
      end else begin
         bit sr, pr;
         int prev;
         sr = start && !m_ps;
         pr = stop && !m_pp;
         m_ps = start;
         m_pp = stop;
         prev = m_mode;
         if (prev == 0) begin
            if (keypad_valid) m_mode = 1;
            else if (QUICK && sr && door_closed) m_mode = 5;
         end else if (prev == 1) begin
            if (pr) m_mode = 0;
            else if (sr && door_closed && !timer_done) m_mode = 2;
         end else if (prev == 2) begin
            if (timer_done) m_mode = 4;
            else if (!door_closed || pr) m_mode = 3;
         end else if (prev == 3) begin
            if (pr) m_mode = 0;
            else if (sr && door_closed) m_mode = 2;
         end else if (prev == 4) begin
            m_beeps_left = m_beeps_left - 1;
            if (pr || m_beeps_left == 0) m_mode = 0;
         end else begin
            m_mode = 2;
         end
         if (m_mode == 4 && prev != 4) m_beeps_left = BEEP;
         m_clear = (m_mode == 0) && (prev == 1 || prev == 3 || prev == 4);
      end
   end

   function automatic logic [9:0] model_vec();
      logic [9:0] v;
      v[9:7] = 3'(m_mode);
      v[6]   = (m_mode == 1 || m_mode == 5);
      v[5]   = (m_mode == 2);
      v[4]   = !m_clear;
      v[3]   = (m_mode == 2);
      v[2]   = (m_mode == 2 || m_mode == 3);
      v[1]   = (m_mode == 4 && m_beeps_left > 0);
      v[0]   = (m_mode == 5);
      return v;
   endfunction

   logic [9:0] dut_vec;
   assign dut_vec = {state, load, enable, timer_clearn, mag_on, lamp_on, beep, quick_preset};

   always @(negedge CLK) begin
      logic [9:0] e;
      e = model_vec();
      n_tests++;
      if (dut_vec !== e) begin
         n_fail++;
         $display("FAIL cycle_model t=%0t got {st,ld,en,clrn,mag,lamp,bp,qp}=%b expected %b",
                  $time, dut_vec, e);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge CLK);
   endtask

   task automatic pulse_key();
      keypad_valid = 1'b1; cyc(); keypad_valid = 1'b0;
   endtask

   task automatic press_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic press_stop();
      stop = 1'b1; cyc(); stop = 1'b0;
   endtask

   initial begin
      int nb, nc, resumes;
      logic [2:0] last;

      cyc(2);
      chk("reset_state", int'(state), 0);
      chk("reset_clearn", int'(timer_clearn), 1);
      chk("reset_mag", int'(mag_on), 0);
      Clearn = 1'b1;
      cyc();

      // Keypad -> SET -> COOK
      pulse_key();
      chk("set_state", int'(state), 1);
      chk("set_load", int'(load), 1);
      press_start();
      chk("cook_state", int'(state), 2);
      chk("cook_load", int'(load), 0);
      chk("cook_mag", int'(mag_on), 1);

      // Door open mid-cook, then resume
      door_closed = 1'b0; cyc();
      chk("pause_state", int'(state), 3);
      chk("pause_mag", int'(mag_on), 0);
      chk("pause_lamp", int'(lamp_on), 1);
      door_closed = 1'b1; cyc();
      press_start();
      chk("resume_state", int'(state), 2);
      chk("resume_load", int'(load), 0);

      // Completion: beep for BEEP cycles then one clear pulse
      timer_done = 1'b1; cyc(); timer_done = 1'b0;
      nb = 0; nc = 0;
      for (int i = 0; i < 6; i++) begin
         nb += int'(beep);
         nc += int'(!timer_clearn);
         cyc();
      end
      chk("done_beep_cycles", nb, 3);
      chk("done_clear_pulses", nc, 1);
      chk("done_back_idle", int'(state), 0);

      // SET with door open ignores start; stop clears
      pulse_key();
      door_closed = 1'b0;
      press_start();
      chk("set_door_open", int'(state), 1);
      door_closed = 1'b1;
      timer_done = 1'b1;
      cyc();
      press_start();
      chk("set_timer_done", int'(state), 1);
      timer_done = 1'b0;
      press_stop();
      chk("set_stop_state", int'(state), 0);
      chk("set_stop_clearn", int'(timer_clearn), 0);
      cyc();
      chk("set_stop_clearn_end", int'(timer_clearn), 1);

      // timer_done beats door open; stop exits DONE early
      pulse_key();
      press_start();
      timer_done = 1'b1; door_closed = 1'b0; cyc();
      timer_done = 1'b0; door_closed = 1'b1;
      chk("done_priority", int'(state), 4);
      press_stop();
      chk("done_stop", int'(state), 0);
      cyc(2);

      // Held start in PAUSE gives exactly one resume
      pulse_key();
      press_start();
      door_closed = 1'b0; cyc(); door_closed = 1'b1;
      start = 1'b1;
      resumes = 0;
      last = state;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (last == 3'd3 && state == 3'd2) resumes++;
         last = state;
      end
      start = 1'b0;
      chk("held_start_resumes", resumes, 1);

      // Held stop in COOK pauses once and does not cancel
      stop = 1'b1; cyc(5); stop = 1'b0;
      chk("held_stop_pause", int'(state), 3);
      cyc();
      press_stop();
      chk("pause_stop_idle", int'(state), 0);
      cyc(2);

      // Start from IDLE: quick start only with the macro
      press_start();
      if (QUICK) begin
         chk("qload_state", int'(state), 5);
         chk("qload_preset", int'(quick_preset), 1);
         cyc();
         chk("qload_cook", int'(state), 2);
         press_stop();
      end else begin
         chk("idle_start_ignored", int'(state), 0);
         chk("idle_no_preset", int'(quick_preset), 0);
         pulse_key();
         press_start();
      end
      cyc();

      // Asynchronous reset mid-cook
      pulse_key();
      door_closed = 1'b1;
      press_start();
      chk("pre_reset_mag", int'(mag_on), 1);
      #2 Clearn = 1'b0;
      #1 chk("async_reset_mag", int'(mag_on), 0);
      cyc();
      Clearn = 1'b1;
      cyc(2);
      chk("after_reset_state", int'(state), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
